// File: rtl/frame_sched_if.sv
// Frame scheduler bus: sample/handshake inputs and scheduling outputs.
interface frame_sched_if #(
  parameter int ADDR_W = 9
) ();
  logic              sched_en;
  logic              sample_valid;
  logic              win_done;
  logic              fft_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] frame_base;
  logic              win_start;
  logic              fft_start;
  logic              busy;
  logic              overrun;
  logic [15:0]       frame_cnt;

  // Environment side: drives samples and stage completions.
  modport master (
    output sched_en, sample_valid, win_done, fft_done,
    input  wr_addr, frame_base, win_start, fft_start, busy, overrun, frame_cnt
  );

  // Scheduler side.
  modport slave (
    input  sched_en, sample_valid, win_done, fft_done,
    output wr_addr, frame_base, win_start, fft_start, busy, overrun, frame_cnt
  );
endinterface

// File: rtl/frame_sched.sv
// Overlapping-frame scheduler: tracks a circular sample buffer and sequences
// the window and FFT stages once a full frame of samples is available.
module frame_sched #(
  parameter int FRAME_LEN = 256,
  parameter int HOP_LEN   = 128,
  parameter int BUF_DEPTH = 512,
  parameter int ADDR_W    = 9
) (
  input  logic          clk,
  input  logic          rst,
  frame_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_WIN_START = 3'd2,
    ST_WIN_RUN   = 3'd3,
    ST_FFT_START = 3'd4,
    ST_FFT_RUN   = 3'd5
  } state_t;

  // fill is one bit wider than an address so a completely full buffer is
  // distinguishable from an empty one.
  localparam logic [ADDR_W:0]   FRAME_LEN_C = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0]   HOP_FILL_C  = (ADDR_W+1)'(HOP_LEN);
  localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W+1)'(BUF_DEPTH);
  localparam logic [ADDR_W:0]   FILL_ONE_C  = {{ADDR_W{1'b0}}, 1'b1};
  // Truncation to ADDR_W bits gives the modulo-BUF_DEPTH address step.
  localparam logic [ADDR_W-1:0] HOP_ADDR_C  = ADDR_W'(HOP_LEN);
  localparam logic [ADDR_W-1:0] ADDR_ONE_C  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [ADDR_W:0]   fill_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [ADDR_W-1:0] frame_base_r;
  logic              win_start_r;
  logic              fft_start_r;
  logic              busy_r;
  logic              overrun_r;
  logic [15:0]       frame_cnt_r;

  logic              accept_s;
  logic              drop_s;
  logic [ADDR_W:0]   fill_next_s;

  // Sample acceptance and next fill level; the hop is consumed while in WIN_START.
  always_comb begin
    accept_s    = bus.sample_valid && (fill_r < DEPTH_C);
    drop_s      = bus.sample_valid && !(fill_r < DEPTH_C);
    fill_next_s = fill_r;
    if (state_r == ST_WIN_START) begin
      fill_next_s = fill_r - HOP_FILL_C + {{ADDR_W{1'b0}}, accept_s};
    end else if (accept_s) begin
      fill_next_s = fill_r + FILL_ONE_C;
    end else begin
      fill_next_s = fill_r;
    end
  end

  // Buffer bookkeeping: fill level, write pointer and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_r    <= '0;
      wr_addr_r <= '0;
      overrun_r <= 1'b0;
    end else begin
      fill_r <= fill_next_s;
      if (accept_s) begin
        wr_addr_r <= wr_addr_r + ADDR_ONE_C;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // Frame sequencing FSM with registered start pulses, busy, base and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      win_start_r  <= 1'b0;
      fft_start_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_base_r <= '0;
      frame_cnt_r  <= 16'd0;
    end else begin
      win_start_r <= 1'b0;
      fft_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.sched_en) begin
            state_r <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (!bus.sched_en) begin
            state_r <= ST_IDLE;
          end else if (fill_r >= FRAME_LEN_C) begin
            state_r     <= ST_WIN_START;
            win_start_r <= 1'b1;
            busy_r      <= 1'b1;
          end
        end
        ST_WIN_START: begin
          state_r <= ST_WIN_RUN;
        end
        ST_WIN_RUN: begin
          // A coincident fft_done is deliberately ignored here.
          if (bus.win_done) begin
            state_r     <= ST_FFT_START;
            fft_start_r <= 1'b1;
          end
        end
        ST_FFT_START: begin
          state_r <= ST_FFT_RUN;
        end
        ST_FFT_RUN: begin
          if (bus.fft_done) begin
            state_r      <= ST_FILL;
            busy_r       <= 1'b0;
            frame_base_r <= frame_base_r + HOP_ADDR_C;
            frame_cnt_r  <= frame_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_addr    = wr_addr_r;
  assign bus.frame_base = frame_base_r;
  assign bus.win_start  = win_start_r;
  assign bus.fft_start  = fft_start_r;
  assign bus.busy       = busy_r;
  assign bus.overrun    = overrun_r;
  assign bus.frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched: reset, framing, hop, overrun, simultaneous
// events, buffer wrap and mid-frame reset.
module tb_frame_sched;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  frame_sched_if #(.ADDR_W(9)) bus ();

  frame_sched #(
    .FRAME_LEN(256), .HOP_LEN(128), .BUF_DEPTH(512), .ADDR_W(9)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edge at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sample_valid = 1'b1;
      @(negedge clk);
    end
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sched_en = 1'b0; bus.sample_valid = 1'b0;
    bus.win_done = 1'b0; bus.fft_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sample_valid = 1'b1;
    tick(); tick();
    total_cnt++; if (bus.wr_addr !== 9'd0) $display("FAIL rst_wr_addr: got %0d want 0", bus.wr_addr); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0 || bus.win_start !== 1'b0 || bus.fft_start !== 1'b0) $display("FAIL rst_ctrl: got busy=%b ws=%b fs=%b want 0", bus.busy, bus.win_start, bus.fft_start); else pass_cnt++;
    total_cnt++; if (bus.frame_base !== 9'd0 || bus.frame_cnt !== 16'd0 || bus.overrun !== 1'b0) $display("FAIL rst_misc: got base=%0d cnt=%0d ovr=%b want 0", bus.frame_base, bus.frame_cnt, bus.overrun); else pass_cnt++;
    bus.sample_valid = 1'b0;
  endtask

  task automatic test_first_frame();
    do_reset();
    bus.sched_en = 1'b1;
    push(256);
    total_cnt++; if (dut.fill_r !== 10'd256 || bus.win_start !== 1'b0) $display("FAIL ff_fill256: got fill=%0d ws=%b want 256/0", dut.fill_r, bus.win_start); else pass_cnt++;
    tick();
    total_cnt++; if (bus.win_start !== 1'b1 || bus.busy !== 1'b1) $display("FAIL ff_win_start: got ws=%b busy=%b want 1/1", bus.win_start, bus.busy); else pass_cnt++;
    total_cnt++; if (bus.frame_base !== 9'd0) $display("FAIL ff_base: got %0d want 0", bus.frame_base); else pass_cnt++;
    tick();
    total_cnt++; if (bus.win_start !== 1'b0 || dut.fill_r !== 10'd128) $display("FAIL ff_after_pulse: got ws=%b fill=%0d want 0/128", bus.win_start, dut.fill_r); else pass_cnt++;
  endtask

  task automatic test_hop();
    bus.win_done = 1'b1; tick(); bus.win_done = 1'b0;
    total_cnt++; if (bus.fft_start !== 1'b1) $display("FAIL hop_fft_start: got %b want 1", bus.fft_start); else pass_cnt++;
    tick();
    total_cnt++; if (bus.fft_start !== 1'b0 || bus.busy !== 1'b1) $display("FAIL hop_fft_run: got fs=%b busy=%b want 0/1", bus.fft_start, bus.busy); else pass_cnt++;
    bus.fft_done = 1'b1; tick(); bus.fft_done = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0 || bus.frame_cnt !== 16'd1 || bus.frame_base !== 9'd128) $display("FAIL hop_done: got busy=%b cnt=%0d base=%0d want 0/1/128", bus.busy, bus.frame_cnt, bus.frame_base); else pass_cnt++;
    push(127); tick();
    total_cnt++; if (bus.win_start !== 1'b0) $display("FAIL hop_early: got ws=%b want 0", bus.win_start); else pass_cnt++;
    push(1); tick();
    total_cnt++; if (bus.win_start !== 1'b1 || bus.frame_base !== 9'd128 || bus.frame_cnt !== 16'd1) $display("FAIL hop_second: got ws=%b base=%0d cnt=%0d want 1/128/1", bus.win_start, bus.frame_base, bus.frame_cnt); else pass_cnt++;
    total_cnt++; if (bus.wr_addr !== 9'd384) $display("FAIL hop_wr_addr: got %0d want 384", bus.wr_addr); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.sched_en = 1'b1;
    push(256);
    bus.sample_valid = 1'b1; tick();
    total_cnt++; if (bus.win_start !== 1'b1 || dut.fill_r !== 10'd257) $display("FAIL sim_ws: got ws=%b fill=%0d want 1/257", bus.win_start, dut.fill_r); else pass_cnt++;
    tick(); bus.sample_valid = 1'b0;
    total_cnt++; if (dut.fill_r !== 10'd130) $display("FAIL sim_fill: got %0d want 130", dut.fill_r); else pass_cnt++;
    bus.win_done = 1'b1; bus.fft_done = 1'b1; tick();
    bus.win_done = 1'b0; bus.fft_done = 1'b0;
    total_cnt++; if (bus.fft_start !== 1'b1 || bus.frame_cnt !== 16'd0) $display("FAIL sim_both_done: got fs=%b cnt=%0d want 1/0", bus.fft_start, bus.frame_cnt); else pass_cnt++;
    tick();
    total_cnt++; if (bus.fft_start !== 1'b0 || bus.busy !== 1'b1) $display("FAIL sim_fft_pulse: got fs=%b busy=%b want 0/1", bus.fft_start, bus.busy); else pass_cnt++;
    bus.fft_done = 1'b1; tick(); bus.fft_done = 1'b0;
    total_cnt++; if (bus.frame_cnt !== 16'd1 || bus.busy !== 1'b0) $display("FAIL sim_complete: got cnt=%0d busy=%b want 1/0", bus.frame_cnt, bus.busy); else pass_cnt++;
  endtask

  task automatic test_overrun();
    do_reset();
    bus.sched_en = 1'b1;
    push(512);
    total_cnt++; if (dut.fill_r !== 10'd384 || bus.wr_addr !== 9'd0) $display("FAIL ovr_384: got fill=%0d wr=%0d want 384/0", dut.fill_r, bus.wr_addr); else pass_cnt++;
    push(128);
    total_cnt++; if (dut.fill_r !== 10'd512 || bus.wr_addr !== 9'd128 || bus.overrun !== 1'b0) $display("FAIL ovr_full: got fill=%0d wr=%0d ovr=%b want 512/128/0", dut.fill_r, bus.wr_addr, bus.overrun); else pass_cnt++;
    push(1);
    total_cnt++; if (dut.fill_r !== 10'd512 || bus.wr_addr !== 9'd128 || bus.overrun !== 1'b1) $display("FAIL ovr_drop: got fill=%0d wr=%0d ovr=%b want 512/128/1", dut.fill_r, bus.wr_addr, bus.overrun); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", bus.overrun); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [8:0] base_tbl [5];
    base_tbl = '{9'd0, 9'd128, 9'd256, 9'd384, 9'd0};
    do_reset();
    bus.sched_en = 1'b1;
    push(256);
    for (int f = 0; f < 4; f++) begin
      tick();
      total_cnt++; if (bus.win_start !== 1'b1 || bus.frame_base !== base_tbl[f]) $display("FAIL wrap_base%0d: got ws=%b base=%0d want 1/%0d", f, bus.win_start, bus.frame_base, base_tbl[f]); else pass_cnt++;
      tick();
      bus.win_done = 1'b1; tick(); bus.win_done = 1'b0;
      tick();
      bus.fft_done = 1'b1; tick(); bus.fft_done = 1'b0;
      total_cnt++; if (bus.frame_cnt !== 16'(f + 1)) $display("FAIL wrap_cnt%0d: got %0d want %0d", f, bus.frame_cnt, f + 1); else pass_cnt++;
      push(128);
    end
    tick();
    total_cnt++; if (bus.win_start !== 1'b1 || bus.frame_base !== base_tbl[4]) $display("FAIL wrap_base4: got ws=%b base=%0d want 1/0", bus.win_start, bus.frame_base); else pass_cnt++;
    total_cnt++; if (bus.wr_addr !== 9'd256) $display("FAIL wrap_wr_addr: got %0d want 256", bus.wr_addr); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    do_reset();
    bus.sched_en = 1'b1;
    push(256);
    tick(); tick();
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL mid_in_win_run: got busy=%b want 1", bus.busy); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (bus.busy !== 1'b0 || bus.wr_addr !== 9'd0 || bus.win_start !== 1'b0 || dut.fill_r !== 10'd0) $display("FAIL mid_async: got busy=%b wr=%0d ws=%b fill=%0d want 0", bus.busy, bus.wr_addr, bus.win_start, dut.fill_r); else pass_cnt++;
    tick(); rst = 1'b0;
    for (int i = 0; i < 255; i++) begin
      bus.sample_valid = 1'b1;
      tick();
      if (bus.win_start === 1'b1) seen++;
    end
    bus.sample_valid = 1'b0;
    tick(); tick();
    if (bus.win_start === 1'b1) seen++;
    total_cnt++; if (seen !== 0) $display("FAIL mid_no_pulse: got %0d pulses want 0", seen); else pass_cnt++;
    push(1); tick();
    total_cnt++; if (bus.win_start !== 1'b1) $display("FAIL mid_restart: got ws=%b want 1", bus.win_start); else pass_cnt++;
  endtask

  // Scenario sequence and summary.
  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b0;
    bus.sched_en = 1'b0; bus.sample_valid = 1'b0;
    bus.win_done = 1'b0; bus.fft_done = 1'b0;
    #2;
    test_reset();
    test_first_frame();
    test_hop();
    test_simultaneous();
    test_overrun();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FRAME_LEN, 256: samples per analysis frame.
- HOP_LEN, 128: frame advance in samples; 1 <= HOP_LEN <= FRAME_LEN.
- BUF_DEPTH, 512: circular sample buffer depth; power of 2; >= FRAME_LEN + HOP_LEN.
- ADDR_W, 9: log2(BUF_DEPTH).

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: the single clock; all logic on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- sched_en, in, 1: enables frame triggering.
- sample_valid, in, 1: one new sample is written this cycle.
- win_done, in, 1: window stage has finished the current frame.
- fft_done, in, 1: FFT stage has finished the current frame.
- wr_addr, out, ADDR_W: buffer address for the incoming sample.
- frame_base, out, ADDR_W: buffer address of sample 0 of the current frame.
- win_start, out, 1: one-cycle start pulse to the window stage.
- fft_start, out, 1: one-cycle start pulse to the FFT stage.
- busy, out, 1: a frame is in process.
- overrun, out, 1: sticky flag; a sample was dropped.
- frame_cnt, out, 16: number of frames completed.

Function
REQ-003 FSM states: IDLE, FILL, WIN_START, WIN_RUN, FFT_START, FFT_RUN; encoding is free.
REQ-004 IDLE transitions:
- IDLE -> FILL when sched_en=1.
- Stays in IDLE otherwise.
REQ-005 FILL transitions:
- FILL -> WIN_START when fill >= FRAME_LEN and sched_en=1.
- FILL -> IDLE when sched_en=0.
REQ-006 WIN_START:
- Lasts exactly 1 cycle with win_start=1, then goes to WIN_RUN.
REQ-007 WIN_RUN:
- WIN_RUN -> FFT_START on the first cycle win_done=1.
- win_done seen in any other state is ignored.
REQ-008 FFT_START:
- Lasts exactly 1 cycle with fft_start=1, then goes to FFT_RUN.
REQ-009 FFT_RUN completion (first cycle fft_done=1):
- Go to FILL.
- frame_cnt increments by 1, wrapping at 2^16.
- fft_done seen in any other state is ignored.
REQ-010 busy = 1 in the states WIN_START, WIN_RUN, FFT_START and FFT_RUN; busy = 0 otherwise.
REQ-011 sched_en is sampled only in IDLE and FILL; deasserting it while busy does not abort the current frame.
REQ-012 fill counter (ADDR_W+1 bits, internal):
- Counts buffered samples that have not yet been consumed.
- Increments on each accepted sample, in every state, including while busy.
REQ-013 Sample acceptance and overrun:
- A sample is accepted when sample_valid=1 and fill < BUF_DEPTH.
- If sample_valid=1 and fill == BUF_DEPTH, the sample is dropped: wr_addr and fill hold, and overrun is set.
REQ-014 overrun is cleared only by reset.
REQ-015 wr_addr increments modulo BUF_DEPTH on each accepted sample.
REQ-016 On entry to WIN_START:
- fill is reduced by HOP_LEN.
- If a sample is accepted in the same cycle, fill becomes fill - HOP_LEN + 1.
REQ-017 frame_base update:
- frame_base is held constant from WIN_START through FFT_RUN.
- It advances by HOP_LEN modulo BUF_DEPTH in the cycle the FSM leaves FFT_RUN.
REQ-018 Overlap: because only HOP_LEN samples are consumed per frame, FRAME_LEN - HOP_LEN samples are retained, so each subsequent frame needs HOP_LEN new samples.
REQ-019 Start pulses are registered outputs: win_start and fft_start are never asserted for 2 consecutive cycles.
REQ-020 Simultaneous done inputs:
- If win_done and fft_done are both 1 in WIN_RUN, only win_done is acted on.
- The FSM does not skip FFT_START.

Reset
REQ-021 While rst=1, asynchronously:
- State = IDLE.
- fill = 0.
- wr_addr = 0, frame_base = 0.
- win_start = 0, fft_start = 0, busy = 0, overrun = 0.
- frame_cnt = 0.
REQ-022 Reset asserted mid-frame:
- Abandons the frame immediately.
- No start pulse is issued in the first cycle after rst deasserts.

Verification
REQ-023 The bench shall run with default parameters and cover these scenarios:
- First frame: sched_en=1; 256 consecutive samples -> win_start pulses 1 cycle after fill reaches 256; frame_base=0; fill=128 after the pulse.
- Hop: complete frame 1 (win_done, then fft_done) and stream 128 more samples -> second win_start; frame_base=128; frame_cnt=1.
- Overrun: sched_en=1; 512 samples with win_done held 0 -> after the first frame fill is 384; samples keep being accepted until fill=512; the next sample -> overrun=1, and wr_addr/fill unchanged.
- Simultaneous events: sample_valid=1 in the WIN_START cycle -> fill = old fill - 128 + 1; win_done and fft_done both 1 in WIN_RUN -> FFT_START still occurs with a 1-cycle fft_start.
- Wrap: run 4 frames -> frame_base sequence 0, 128, 256, 384, then 0; wr_addr wraps 511 -> 0.
- Reset mid-frame: rst=1 during WIN_RUN -> all outputs 0 immediately; after release, no pulse until 256 new samples arrive.
